// File: rtl/sap_core_param.sv
// Parametrised multi-cycle accumulator core with streaming program load.
// Two-cycle FETCH/EXEC instructions over a DEPTH-word register RAM.
module sap_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              load_done,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid,
    output logic              halted,
    output logic              cf,
    output logic              zf
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              done_q, done_d;
    logic              ov_q, ov_d;
    logic              cf_q, cf_d;
    logic              zf_q, zf_d;

    logic [DATA_W-1:0] ram_q [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    logic [3:0]        opc;
    logic [ADDR_W-1:0] opa;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W:0]   sum;
    logic              unused_ok;

    assign opc    = ir_q[DATA_W-1 -: 4];
    assign opa    = ir_q[ADDR_W-1:0];
    assign mem_rd = ram_q[opa];

    // SUB as A + ~M + 1 so the carry-out doubles as the no-borrow flag
    assign sum = (opc == OP_SUB)
               ? {1'b0, a_q} + {1'b0, ~mem_rd} + (DATA_W+1)'(1)
               : {1'b0, a_q} + {1'b0, mem_rd};

    assign prog_ready = (state_q == S_LOAD);
    assign halted     = (state_q == S_HALT);
    assign load_done  = done_q;
    assign out_value  = out_q;
    assign out_valid  = ov_q;
    assign cf         = cf_q;
    assign zf         = zf_q;
    assign unused_ok  = ^{b_q, ir_q};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        ir_d    = ir_q;
        out_d   = out_q;
        done_d  = done_q;
        ov_d    = 1'b0;
        cf_d    = cf_q;
        zf_d    = zf_q;
        we      = 1'b0;
        waddr   = ptr_q;
        wdata   = prog_data;
        unique case (state_q)
            S_IDLE: begin
                if (prog_mode) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    done_d  = 1'b0;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_LOAD: begin
                if (prog_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                end
                if (prog_valid && ptr_q == '1) begin
                    done_d  = 1'b1;
                    state_d = S_FETCH;
                    pc_d    = '0;
                end else if (!prog_mode) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = ram_q[pc_q];
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                unique case (opc)
                    OP_LDA: a_d = mem_rd;
                    OP_ADD, OP_SUB: begin
                        b_d  = mem_rd;
                        a_d  = sum[DATA_W-1:0];
                        cf_d = sum[DATA_W];
                        zf_d = ~|sum[DATA_W-1:0];
                    end
                    OP_STA: begin
                        we    = 1'b1;
                        waddr = opa;
                        wdata = a_q;
                    end
                    OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, opa};
                    OP_JMP: pc_d = opa;
                    OP_JC:  if (cf_q) pc_d = opa;
                    OP_JZ:  if (zf_q) pc_d = opa;
                    OP_OUT: begin
                        out_d = a_q;
                        ov_d  = 1'b1;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: begin
                if (prog_mode) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ptr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ir_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            if (we) ram_q[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_sap_core_param.sv
// Bench for sap_core_param: instruction-level reference model for the
// 8-bit core plus directed checks of a 12-bit/64-word instance.
module tb_sap_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, pm, pv;
    logic [7:0] pd;
    logic       pr, ld, ovld, hlt, cf, zf;
    logic [7:0] ov;

    logic        rst2, pm2, pv2;
    logic [11:0] pd2;
    logic        pr2, ld2, ovld2, hlt2, cf2, zf2;
    logic [11:0] ov2;

    sap_core_param #(.DATA_W(8), .ADDR_W(4)) dut8 (
        .clk(clk), .rst(rst), .prog_mode(pm), .prog_valid(pv),
        .prog_data(pd), .prog_ready(pr), .load_done(ld),
        .out_value(ov), .out_valid(ovld), .halted(hlt),
        .cf(cf), .zf(zf)
    );

    sap_core_param #(.DATA_W(12), .ADDR_W(6)) dut12 (
        .clk(clk), .rst(rst2), .prog_mode(pm2), .prog_valid(pv2),
        .prog_data(pd2), .prog_ready(pr2), .load_done(ld2),
        .out_value(ov2), .out_valid(ovld2), .halted(hlt2),
        .cf(cf2), .zf(zf2)
    );

    int checks = 0;
    int errors = 0;

    // Instruction-level model state
    logic [7:0] m_ram [16];
    int         m_a;
    bit         m_cf, m_zf, m_halt;
    int         m_steps;
    logic [7:0] m_out;
    logic [7:0] m_outs [$];
    logic [7:0] d_outs [$];
    logic [7:0] prog [16];

    function automatic void model_run(input int lim);
        int pc, op, a, s;
        logic [7:0] ir;
        pc = 0;
        m_steps = 0;
        m_halt = 0;
        m_outs.delete();
        while (m_steps < lim && !m_halt) begin
            ir = m_ram[pc];
            pc = (pc + 1) % 16;
            op = int'(ir) / 16;
            a = int'(ir) % 16;
            m_steps++;
            case (op)
                1: m_a = int'(m_ram[a]);
                2: begin
                    s = m_a + int'(m_ram[a]);
                    m_cf = (s > 255);
                    m_a = s % 256;
                    m_zf = (m_a == 0);
                end
                3: begin
                    m_cf = (m_a >= int'(m_ram[a]));
                    m_a = (m_a - int'(m_ram[a]) + 256) % 256;
                    m_zf = (m_a == 0);
                end
                4: m_ram[a] = 8'(m_a);
                5: m_a = a;
                6: pc = a;
                7: if (m_cf) pc = a;
                8: if (m_zf) pc = a;
                14: begin
                    m_out = 8'(m_a);
                    m_outs.push_back(m_out);
                end
                15: m_halt = 1;
                default: ;
            endcase
        end
    endfunction

    task automatic do_reset(input bit mode);
        rst = 1'b1;
        pm = mode;
        pv = 1'b0;
        pd = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pr, ld, ov, ovld, hlt, cf, zf} !== 14'b0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {pr, ld, ov, ovld, hlt, cf, zf});
        end
        rst = 1'b0;
        foreach (m_ram[i]) m_ram[i] = '0;
        m_a = 0;
        m_cf = 0;
        m_zf = 0;
        m_out = '0;
    endtask

    task automatic load_words(input int n);
        int t;
        pm = 1'b1;
        t = 0;
        @(negedge clk);
        while (!pr && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (pr !== 1'b1 || ld !== 1'b0) begin
            errors++;
            $display("FAIL load_entry ready=%b done=%b want 1 0", pr, ld);
        end
        for (int i = 0; i < n; i++) begin
            pv = 1'b1;
            pd = prog[i];
            m_ram[i] = prog[i];
            @(negedge clk);
        end
        pv = 1'b0;
        pm = 1'b0;
        checks++;
        if (ld !== (n == 16)) begin
            errors++;
            $display("FAIL load_done n=%0d got %b want %b", n, ld, n == 16);
        end
    endtask

    task automatic run_check(input string name, input int off);
        int exp_cnt, cnt;
        bit ok;
        model_run(100);
        exp_cnt = 2 * m_steps + off;
        d_outs.delete();
        cnt = 0;
        while (cnt < exp_cnt) begin
            @(negedge clk);
            cnt++;
            if (ovld) d_outs.push_back(ov);
            if (hlt && cnt < exp_cnt) break;
        end
        checks++;
        if (cnt !== exp_cnt || hlt !== m_halt) begin
            errors++;
            $display("FAIL %s_timing cycles=%0d halted=%b want %0d %b",
                     name, cnt, hlt, exp_cnt, m_halt);
        end
        ok = (d_outs.size() == m_outs.size());
        if (ok) foreach (d_outs[i]) if (d_outs[i] !== m_outs[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_outs got %p want %p", name, d_outs, m_outs);
        end
        checks++;
        if (ov !== m_out || cf !== m_cf || zf !== m_zf) begin
            errors++;
            $display("FAIL %s_state out=%h cf=%b zf=%b want %h %b %b",
                     name, ov, cf, zf, m_out, m_cf, m_zf);
        end
    endtask

    task automatic clear_prog();
        foreach (prog[i]) prog[i] = '0;
    endtask

    task automatic test_reset();
        bit seen;
        do_reset(1'b0);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ovld || hlt) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL empty_ram_run saw out_valid/halted got 1 want 0");
        end
    endtask

    task automatic test_basic();
        do_reset(1'b1);
        clear_prog();
        prog[0] = 8'h14; prog[1] = 8'h25; prog[2] = 8'hE0;
        prog[3] = 8'hF0; prog[4] = 8'h05; prog[5] = 8'h03;
        load_words(16);
        run_check("basic", 0);
        checks++;
        if (ov !== 8'h08 || d_outs.size() != 1) begin
            errors++;
            $display("FAIL basic_value got %h n=%0d want 08 1",
                     ov, d_outs.size());
        end
    endtask

    task automatic test_reload_full();
        clear_prog();
        prog[0] = 8'h2A; prog[1] = 8'hE0; prog[2] = 8'h4B;
        prog[3] = 8'h1B; prog[4] = 8'h3A; prog[5] = 8'hE0;
        prog[6] = 8'hF0; prog[10] = 8'hC9;
        load_words(16);
        run_check("reload_full", 0);
    endtask

    task automatic test_arith(input logic [7:0] opw, input logic [7:0] x,
                              input logic [7:0] y, input logic [7:0] r,
                              input bit ecf, input bit ezf);
        do_reset(1'b1);
        clear_prog();
        prog[0] = 8'h18; prog[1] = opw; prog[2] = 8'hE0;
        prog[3] = 8'h75; prog[4] = 8'hE0; prog[5] = 8'hF0;
        prog[8] = x; prog[9] = y;
        load_words(16);
        run_check("arith", 0);
        checks++;
        if (d_outs.size() == 0 || d_outs[0] !== r || cf !== ecf
            || zf !== ezf || d_outs.size() != (ecf ? 1 : 2)) begin
            errors++;
            $display("FAIL arith_%h_%h out=%h cf=%b zf=%b n=%0d want %h %b %b",
                     x, y, ov, cf, zf, d_outs.size(), r, ecf, ezf);
        end
    endtask

    task automatic test_loop();
        do_reset(1'b1);
        clear_prog();
        prog[0] = 8'h53; prog[1] = 8'h37; prog[2] = 8'h85;
        prog[3] = 8'h61; prog[5] = 8'hE0; prog[6] = 8'hF0;
        prog[7] = 8'h01;
        load_words(16);
        run_check("loop", 0);
        checks++;
        if (ov !== 8'h00 || zf !== 1'b1 || d_outs.size() != 1) begin
            errors++;
            $display("FAIL loop_end out=%h zf=%b n=%0d want 00 1 1",
                     ov, zf, d_outs.size());
        end
    endtask

    task automatic test_partial_wrap();
        do_reset(1'b1);
        clear_prog();
        prog[0] = 8'h73; prog[1] = 8'h23; prog[2] = 8'h64; prog[3] = 8'hF1;
        load_words(4);
        run_check("partial_wrap", 1);
    endtask

    task automatic test_reload_partial();
        clear_prog();
        prog[0] = 8'hE0; prog[1] = 8'hF0;
        load_words(2);
        run_check("reload_partial", 1);
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset(1'b1);
        clear_prog();
        prog[4] = 8'h77;
        pm = 1'b1;
        t = 0;
        @(negedge clk);
        while (!pr && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            pv = 1'b1;
            pd = prog[i];
            @(negedge clk);
        end
        do_reset(1'b1);
        @(negedge clk);
        checks++;
        if (pr !== 1'b1) begin
            errors++;
            $display("FAIL reset_to_load ready=%b want 1", pr);
        end
        clear_prog();
        prog[0] = 8'h14; prog[1] = 8'hE0; prog[2] = 8'hF0;
        load_words(3);
        run_check("ram_cleared", 1);
        do_reset(1'b1);
        clear_prog();
        prog[0] = 8'h14; prog[1] = 8'h25; prog[2] = 8'hE0;
        prog[3] = 8'hF0; prog[4] = 8'h05; prog[5] = 8'h03;
        load_words(16);
        repeat (7) @(negedge clk);
        checks++;
        if (ov !== 8'h08 || hlt !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset out=%h halted=%b want 08 0", ov, hlt);
        end
        do_reset(1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            do_reset(1'b1);
            foreach (prog[i]) prog[i] = 8'($urandom_range(0, 255));
            load_words(16);
            run_check($sformatf("random%0d", k), 0);
        end
    endtask

    task automatic test_param12();
        int cnt, pulses;
        rst2 = 1'b1;
        pm2 = 1'b1;
        pv2 = 1'b0;
        pd2 = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({pr2, ld2, ov2, ovld2, hlt2, cf2, zf2} !== 18'b0) begin
            errors++;
            $display("FAIL p12_reset got %h want 0",
                     {pr2, ld2, ov2, ovld2, hlt2, cf2, zf2});
        end
        rst2 = 1'b0;
        @(negedge clk);
        checks++;
        if (pr2 !== 1'b1) begin
            errors++;
            $display("FAIL p12_ready got %b want 1", pr2);
        end
        for (int i = 0; i < 64; i++) begin
            pv2 = 1'b1;
            case (i)
                0:  pd2 = 12'h13E;
                1:  pd2 = 12'h23F;
                2:  pd2 = 12'hE00;
                3:  pd2 = 12'hF00;
                62: pd2 = 12'hFFF;
                63: pd2 = 12'h001;
                default: pd2 = 12'h000;
            endcase
            @(negedge clk);
            if (i == 62) begin
                checks++;
                if (ld2 !== 1'b0) begin
                    errors++;
                    $display("FAIL p12_done_early got %b want 0", ld2);
                end
            end
        end
        pv2 = 1'b0;
        pm2 = 1'b0;
        checks++;
        if (ld2 !== 1'b1) begin
            errors++;
            $display("FAIL p12_done got %b want 1", ld2);
        end
        cnt = 0;
        pulses = 0;
        while (!hlt2 && cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (ovld2) pulses++;
        end
        checks++;
        if (cnt != 8 || ov2 !== 12'h000 || cf2 !== 1'b1 || zf2 !== 1'b1
            || pulses != 1) begin
            errors++;
            $display("FAIL p12_add cyc=%0d out=%h cf=%b zf=%b p=%0d want 8 000 1 1 1",
                     cnt, ov2, cf2, zf2, pulses);
        end
    endtask

    initial begin
        rst = 1'b1; pm = 1'b0; pv = 1'b0; pd = '0;
        rst2 = 1'b1; pm2 = 1'b0; pv2 = 1'b0; pd2 = '0;
        test_reset();
        test_basic();
        test_reload_full();
        test_arith(8'h39, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
        test_arith(8'h39, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
        test_arith(8'h29, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        test_arith(8'h29, 8'h40, 8'h21, 8'h61, 1'b0, 1'b0);
        test_loop();
        test_partial_wrap();
        test_reload_partial();
        test_reset_mid();
        test_random();
        test_param12();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
